// File: rtl/pipeline_control_sequencer_if.sv
// Control bundle between the pipeline hazard/redirect sources and the stage-control sequencer.
// The master drives the pipeline events; the slave (sequencer) returns stage controls and status.
interface pipeline_control_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             data_hazard;
  logic             branch_redirect;
  logic             mem_busy;
  logic             perf_clear;
  logic             hold_fetch;
  logic             hold_decode;
  logic             bubble_execute;
  logic             hold_memory;
  logic             flush;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_count;
  logic             timeout_err;

  modport master (
    output data_hazard, branch_redirect, mem_busy, perf_clear,
    input  hold_fetch, hold_decode, bubble_execute, hold_memory, flush,
    input  state, stall_count, timeout_err
  );

  modport slave (
    input  data_hazard, branch_redirect, mem_busy, perf_clear,
    output hold_fetch, hold_decode, bubble_execute, hold_memory, flush,
    output state, stall_count, timeout_err
  );
endinterface

// File: rtl/pipeline_control_sequencer.sv
// Pipeline stall/flush sequencer: arbitrates memory waits, branch redirects and RAW hazards
// into per-stage hold/bubble/flush controls, with stall and memory-timeout monitoring.
module pipeline_control_sequencer #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned MEM_TIMEOUT  = 1023,
  parameter int unsigned CNT_W        = 16
) (
  input logic                        clock,
  input logic                        reset,
  pipeline_control_sequencer_if.slave bus
);

  localparam int unsigned FC_W   = 4;
  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [FC_W-1:0]   FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HAZARD  = 2'd1,
    FLUSH   = 2'd2,
    MEMWAIT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic             pend_q, pend_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic             timeout_q;
  logic [CNT_W-1:0] stall_q;
  logic             hold_fetch_c, hold_decode_c, bubble_execute_c, hold_memory_c, flush_c;
  logic             redirect_c, stall_c;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      pend_q      <= pend_d;
    end
  end

  // Next state and same-cycle stage controls; memory wait outranks everything.
  always_comb begin
    state_d          = state_q;
    flush_cnt_d      = flush_cnt_q;
    pend_d           = pend_q;
    hold_fetch_c     = 1'b0;
    hold_decode_c    = 1'b0;
    bubble_execute_c = 1'b0;
    hold_memory_c    = 1'b0;
    flush_c          = 1'b0;
    redirect_c       = 1'b0;
    stall_c          = 1'b0;
    if (bus.mem_busy) begin
      hold_fetch_c  = 1'b1;
      hold_decode_c = 1'b1;
      hold_memory_c = 1'b1;
      state_d       = MEMWAIT;
      if (bus.branch_redirect || (state_q == FLUSH)) pend_d = 1'b1;
    end else if (state_q == FLUSH) begin
      flush_c = 1'b1;
      if (bus.branch_redirect) flush_cnt_d = FLUSH_LOAD;
      else if (flush_cnt_q == '0) state_d = bus.data_hazard ? HAZARD : RUN;
      else flush_cnt_d = flush_cnt_q - FC_W'(1);
    end else begin
      // A hazard coincident with a redirect still stalls; the redirect only decides the next state.
      redirect_c       = bus.branch_redirect || pend_q;
      stall_c          = bus.data_hazard || ((state_q == HAZARD) && !redirect_c);
      hold_fetch_c     = stall_c;
      hold_decode_c    = stall_c;
      bubble_execute_c = stall_c;
      if (redirect_c) begin
        state_d     = FLUSH;
        flush_cnt_d = FLUSH_LOAD;
        pend_d      = 1'b0;
      end else if (bus.data_hazard) begin
        state_d = HAZARD;
      end else begin
        state_d = RUN;
      end
    end
    if (!reset) begin
      hold_fetch_c     = 1'b0;
      hold_decode_c    = 1'b0;
      bubble_execute_c = 1'b0;
      hold_memory_c    = 1'b0;
      flush_c          = 1'b0;
    end
  end

  always_comb begin
    wait_d = '0;
    if (bus.mem_busy) wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);
  end

  // Consecutive memory-wait run length and sticky timeout.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      timeout_q <= timeout_q | (wait_d == WAIT_MAX);
    end
  end

  // Saturating count of fetch-hold cycles; clear wins over increment.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (bus.perf_clear) begin
      stall_q <= '0;
    end else if (hold_fetch_c && (stall_q != '1)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign bus.hold_fetch     = hold_fetch_c;
  assign bus.hold_decode    = hold_decode_c;
  assign bus.bubble_execute = bubble_execute_c;
  assign bus.hold_memory    = hold_memory_c;
  assign bus.flush          = flush_c;
  assign bus.state          = state_q;
  assign bus.stall_count    = stall_q;
  assign bus.timeout_err    = timeout_q;

endmodule

// File: tb/tb_pipeline_control_sequencer.sv
// Bench for pipeline_control_sequencer: directed scenarios plus randomized traffic,
// every cycle compared against a cycle-budget reference model.
module tb_pipeline_control_sequencer;

  localparam int unsigned FC = 2;
  localparam int unsigned MT = 8;
  localparam int unsigned CW = 6;
  localparam int SC_MAX = (1 << CW) - 1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  pipeline_control_sequencer_if #(.CNT_W(CW)) bus ();

  pipeline_control_sequencer #(
    .FLUSH_CYCLES (FC),
    .MEM_TIMEOUT  (MT),
    .CNT_W        (CW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: mode, flush cycles still owed, pending redirect, busy run length.
  int m_st, m_left, m_wait, m_sc;
  bit m_pend, m_to;

  logic [31:0] o_hf, o_hd, o_bx, o_hm, o_fl, o_st, o_sc, o_to;

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    n_tests++;
    assert (got === 32'(exp)) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_st = 0; m_left = 0; m_wait = 0; m_sc = 0; m_pend = 1'b0; m_to = 1'b0;
  endfunction

  // One clock cycle: drive at the falling edge, sample 1 ns later, advance the model.
  task automatic step(input logic dh, input logic br, input logic mb, input logic pc);
    int e_hf = 0, e_hd = 0, e_bx = 0, e_hm = 0, e_fl = 0;
    int e_st, e_sc, e_to, n_st;
    bit redir, stall;
    bus.data_hazard = dh; bus.branch_redirect = br; bus.mem_busy = mb; bus.perf_clear = pc;
    #1;
    o_hf = 32'(bus.hold_fetch);  o_hd = 32'(bus.hold_decode); o_bx = 32'(bus.bubble_execute);
    o_hm = 32'(bus.hold_memory); o_fl = 32'(bus.flush);       o_st = 32'(bus.state);
    o_sc = 32'(bus.stall_count); o_to = 32'(bus.timeout_err);
    e_st = m_st; e_sc = m_sc; e_to = int'(m_to);
    n_st = m_st;
    if (mb) begin
      e_hf = 1; e_hd = 1; e_hm = 1;
      if (br || m_st == 2) m_pend = 1'b1;
      n_st = 3;
    end else if (m_st == 2) begin
      e_fl = 1;
      m_left = m_left - 1;
      if (br) m_left = FC;
      if (m_left == 0) n_st = dh ? 1 : 0;
    end else begin
      redir = br || (m_st == 3 && m_pend);
      stall = dh || (m_st == 1 && !redir);
      e_hf = int'(stall); e_hd = int'(stall); e_bx = int'(stall);
      if (redir) begin
        n_st = 2; m_left = FC; m_pend = 1'b0;
      end else begin
        n_st = dh ? 1 : 0;
      end
    end
    chk("hold_fetch", o_hf, e_hf);
    chk("hold_decode", o_hd, e_hd);
    chk("bubble_execute", o_bx, e_bx);
    chk("hold_memory", o_hm, e_hm);
    chk("flush", o_fl, e_fl);
    chk("state", o_st, e_st);
    chk("stall_count", o_sc, e_sc);
    chk("timeout_err", o_to, e_to);
    m_wait = mb ? ((m_wait < int'(MT)) ? m_wait + 1 : m_wait) : 0;
    if (m_wait >= int'(MT)) m_to = 1'b1;
    if (pc) m_sc = 0;
    else if (e_hf == 1 && m_sc < SC_MAX) m_sc = m_sc + 1;
    m_st = n_st;
    cyc++;
    @(negedge clock);
  endtask

  task automatic idle_until(input int n);
    while (cyc < n) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit mb_r;
    reset = 1'b0;
    bus.data_hazard = 1'b1; bus.branch_redirect = 1'b1; bus.mem_busy = 1'b1; bus.perf_clear = 1'b0;
    #2;
    chk("rst_hold_fetch", 32'(bus.hold_fetch), 0);
    chk("rst_hold_memory", 32'(bus.hold_memory), 0);
    chk("rst_bubble", 32'(bus.bubble_execute), 0);
    chk("rst_flush", 32'(bus.flush), 0);
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_stall_count", 32'(bus.stall_count), 0);
    chk("rst_timeout", 32'(bus.timeout_err), 0);
    @(negedge clock);
    reset = 1'b1;
    model_reset();

    // Hazard cycles 5-7 with tail at 8
    idle_until(5);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("haz_tail_hold", o_hf, 1); chk("haz_tail_bubble", o_bx, 1); chk("haz_tail_state", o_st, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("haz_run_state", o_st, 0); chk("haz_stall_count", o_sc, 4);

    // Redirect at 10: flush 11-12, RUN at 13
    idle_until(10);
    step(1'b0, 1'b1, 1'b0, 1'b0); chk("redir_no_flush", o_fl, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0); chk("redir_flush1", o_fl, 1); chk("redir_state", o_st, 2);
    step(1'b0, 1'b0, 1'b0, 1'b0); chk("redir_flush2", o_fl, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0); chk("redir_done_flush", o_fl, 0); chk("redir_done_state", o_st, 0);

    // Busy 20-24 with redirect at 22: deferred flush 26-27
    idle_until(20);
    for (int c = 20; c <= 24; c++) begin
      step(1'b0, (c == 22), 1'b1, 1'b0);
      chk("busy_hold_memory", o_hm, 1); chk("busy_no_flush", o_fl, 0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0); chk("busy_exit_flush", o_fl, 0); chk("busy_exit_state", o_st, 3);
    step(1'b0, 1'b0, 1'b0, 1'b0); chk("pend_flush1", o_fl, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0); chk("pend_flush2", o_fl, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0); chk("pend_done", o_fl, 0); chk("pend_stall_count", o_sc, 9);

    // Hazard and redirect together at 30
    idle_until(30);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("combo_hold", o_hf, 1); chk("combo_bubble", o_bx, 1); chk("combo_no_flush", o_fl, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("combo_flush1", o_fl, 1); chk("combo_hazard_ignored", o_hf, 0); chk("combo_state", o_st, 2);
    step(1'b0, 1'b0, 1'b0, 1'b0); chk("combo_flush2", o_fl, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0); chk("combo_run", o_st, 0); chk("combo_stall_count", o_sc, 10);

    // Ten busy cycles from 40: timeout after the eighth, sticky afterwards
    idle_until(40);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      if (i == 7) chk("timeout_before", o_to, 0);
      if (i == 8) chk("timeout_after", o_to, 1);
    end
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("timeout_sticky", o_to, 1);

    // Reset during the second flush cycle
    idle_until(60);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    bus.branch_redirect = 1'b0;
    #1;
    chk("pre_reset_flush", 32'(bus.flush), 1);
    reset = 1'b0;
    #1;
    chk("mid_reset_flush", 32'(bus.flush), 0);
    chk("mid_reset_state", 32'(bus.state), 0);
    chk("mid_reset_stall_count", 32'(bus.stall_count), 0);
    chk("mid_reset_timeout", 32'(bus.timeout_err), 0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0); chk("post_reset_hold", o_hf, 1); chk("post_reset_state", o_st, 0);
    step(1'b1, 1'b0, 1'b0, 1'b1); chk("pre_clear_count", o_sc, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0); chk("clear_wins", o_sc, 0);

    // Randomized traffic with one asynchronous reset in the middle
    mb_r = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 15) mb_r = !mb_r;
      step(($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 12), mb_r,
           ($urandom_range(0, 99) < 1));
      if (i == 300) begin
        reset = 1'b0;
        #1;
        chk("rand_reset_state", 32'(bus.state), 0);
        chk("rand_reset_hold_memory", 32'(bus.hold_memory), 0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        mb_r = 1'b0;
      end
    end

    // Stall counter saturation
    step(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (70) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("stall_saturate", o_sc, SC_MAX);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_control_sequencer.md
PIPELINE_CONTROL_SEQUENCER -- requirements
Module: pipeline_control_sequencer

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, legal 1..15: number of cycles `flush` is asserted per redirect.
REQ-002 Parameter MEM_TIMEOUT, default 1023: count of consecutive memory-wait cycles that sets `timeout_err`.
REQ-003 Parameter CNT_W, default 16: width of `stall_count`.
REQ-004 Port `clock`, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port `reset`, input, 1: reset is asynchronous and active-low.
REQ-006 Port `data_hazard`, input, 1: decode-stage RAW hazard request (level).
REQ-007 Port `branch_redirect`, input, 1: taken branch/jump resolved this cycle (1-cycle pulse).
REQ-008 Port `mem_busy`, input, 1: memory stage cannot complete this cycle (level).
REQ-009 Port `perf_clear`, input, 1: synchronous clear of `stall_count`.
REQ-010 Port `hold_fetch`, output, 1: freeze PC and fetch register.
REQ-011 Port `hold_decode`, output, 1: freeze decode register.
REQ-012 Port `bubble_execute`, output, 1: inject NOP into execute.
REQ-013 Port `hold_memory`, output, 1: freeze execute and memory registers.
REQ-014 Port `flush`, output, 1: squash fetch and decode contents.
REQ-015 Port `state`, output, 2: current FSM encoding.
REQ-016 Port `stall_count`, output, CNT_W: saturating count of cycles with `hold_fetch`=1.
REQ-017 Port `timeout_err`, output, 1: sticky memory-wait timeout flag.

Function
REQ-018 FSM states SHALL be RUN=0, HAZARD=1, FLUSH=2, MEMWAIT=3, driven on `state`.
REQ-019 Priority per cycle SHALL be mem_busy > flush (state FLUSH) > branch_redirect > data_hazard.
REQ-020 mem_busy=1 in any state: hold_fetch=hold_decode=hold_memory=1, bubble_execute=0, flush=0, same cycle; next state MEMWAIT.
REQ-021 branch_redirect=1 with mem_busy=0 in RUN or HAZARD: next state FLUSH, flush counter loaded FLUSH_CYCLES-1; no flush in the redirect cycle itself.
REQ-022 In FLUSH with mem_busy=0: flush=1, all holds and bubble 0; counter decrements; at counter 0 exit to HAZARD if data_hazard=1, else RUN.
REQ-023 branch_redirect in FLUSH SHALL reload the counter to FLUSH_CYCLES-1 (flush extends).
REQ-024 data_hazard=1 in RUN or HAZARD with no higher-priority event: hold_fetch=hold_decode=bubble_execute=1 same cycle; next state HAZARD.
REQ-025 HAZARD with data_hazard=0 and no other event: one tail cycle with hold_fetch=hold_decode=bubble_execute=1, then RUN.
REQ-026 data_hazard SHALL be ignored while in FLUSH or MEMWAIT.
REQ-027 branch_redirect during MEMWAIT or coincident with mem_busy SHALL set redirect_pending; mem_busy in FLUSH SHALL also set redirect_pending (full flush re-run).
REQ-028 MEMWAIT exit (mem_busy=0): redirect_pending -> FLUSH (counter FLUSH_CYCLES-1, pending cleared); else data_hazard -> HAZARD; else RUN; exit-cycle outputs follow the RUN rules.
REQ-029 Wait counter SHALL count consecutive mem_busy cycles, saturate, clear on mem_busy=0; reaching MEM_TIMEOUT sets timeout_err until reset.
REQ-030 stall_count SHALL increment when hold_fetch=1, saturate at all-ones; perf_clear forces 0 and wins over increment.

Reset
REQ-031 reset low SHALL immediately force state RUN, all counters 0, redirect_pending 0, timeout_err 0, and every output 0.
REQ-032 Reset asserted mid-FLUSH or mid-MEMWAIT SHALL abandon the operation; first cycle after release behaves as RUN.

Verification
REQ-033 data_hazard high cycles 5-7 -> holds+bubble cycles 5-8 (tail at 8), state HAZARD 6-8, RUN 9, stall_count=4.
REQ-034 branch_redirect pulse cycle 10, default params -> flush=1 cycles 11-12 only, state RUN cycle 13.
REQ-035 mem_busy cycles 20-24 with branch_redirect at 22 -> hold_memory=1 cycles 20-24, flush=0, then flush=1 cycles 26-27.
REQ-036 data_hazard and branch_redirect together at cycle 30 -> stall that cycle, flush 31-32, data_hazard ignored in 31-32.
REQ-037 MEM_TIMEOUT=8, mem_busy held 10 cycles -> timeout_err rises after 8th busy cycle, stays 1 after mem_busy drops until reset.
REQ-038 Reset pulsed low during FLUSH cycle 2 -> flush and state 0 immediately; stall_count=0; perf_clear coincident with hold -> stall_count=0.
